time_digit_sequencer: RTL
=========================

TIME_DIGIT_SEQUENCER -- requirements
Module: time_digit_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port tick, input, 1, one-cycle pulse requesting +1 second.
REQ-004 SHALL have port adj_min, input, 1, one-cycle pulse requesting +1 minute with no carry into hours.
REQ-005 SHALL have port adj_hr, input, 1, one-cycle pulse requesting +1 hour.
REQ-006 SHALL have ports sec_o, sec_t, min_o, min_t, hr_o, hr_t, output, 4 each, BCD digits (ones/tens).
REQ-007 SHALL have port busy, output, 1, high while the FSM is outside IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when an update sequence completes.
REQ-009 SHALL have port tick_miss, output, 1, one-cycle pulse when a tick is dropped.

Function
REQ-010 SHALL compute every digit increment through exactly one shared 4-bit carry-lookahead adder: a=current digit, b=0, cin=1.
REQ-011 SHALL use FSM states IDLE, SEC_O, SEC_T, MIN_O, MIN_T, HR, DONE; each non-IDLE state lasts exactly one cycle.
REQ-012 SHALL, in IDLE, start on tick at SEC_O, else adj_hr at HR, else adj_min at MIN_O (priority tick > adj_hr > adj_min).
REQ-013 SHALL, in each digit state, write adder sum if below the digit limit (sec_o/min_o 9, sec_t/min_t 5), else write 0 and advance to the next digit state.
REQ-014 SHALL go to DONE without touching higher digits when a digit does not wrap.
REQ-015 SHALL, in MIN_T for an adj_min sequence, go to DONE on wrap (no hour carry).
REQ-016 SHALL, in HR, update hr_t:hr_o as one field in one cycle using the adder on hr_o, with the tens digit handled by compare logic; wrap per REQ-024/025.
REQ-017 SHALL assert done for exactly the DONE cycle, then return to IDLE; worst-case tick latency is 6 cycles from tick to done.
REQ-018 SHALL latch one tick arriving while busy into a pending flag and start it from IDLE on the cycle after DONE.
REQ-019 SHALL drop a tick arriving while pending is already set and pulse tick_miss that cycle.
REQ-020 SHALL ignore adj_min/adj_hr while busy or pending, and ignore them in any cycle where tick is accepted.
REQ-021 SHALL never present a non-BCD digit value on any output.

Reset
REQ-022 SHALL, on rst, set all digits to 0 (or hr to 12 per REQ-025), state IDLE, pending 0, busy/done/tick_miss 0.
REQ-023 SHALL let rst mid-sequence abort the update immediately; partial writes are discarded by the reset values.

Configuration
REQ-024 SHALL, with HOUR_24_EN defined, count hours 00..23; 23 -> 00; reset hours 00.
REQ-025 SHALL, without HOUR_24_EN, count hours 01..12; 12 -> 01; 09 -> 10; reset hours 12.

Structure
REQ-026 SHALL place the FSM state enum, digit limits (9, 5, hour max/min) and state width in shared package clock_pkg.
REQ-027 SHALL instantiate the team's 4-bit carry-lookahead adder CLA4 exactly once as the only sub-module; no other adders.

Verification
REQ-028 SHALL test rollover: preset 12:59:59 (24h), tick -> 13:00:00, done 6 cycles later.
REQ-029 SHALL test day wrap: 23:59:59 with HOUR_24_EN, tick -> 00:00:00; 12:59:59 without it -> 01:00:00.
REQ-030 SHALL test minute adjust: 10:59:30, adj_min -> 10:00:30 (no hour carry), done 3 cycles later.
REQ-031 SHALL test tick overlap: tick at cycles 0, 2, 3 from 00:00:59 -> cycle 2 pends, cycle 3 pulses tick_miss, final 00:01:01.
REQ-032 SHALL test priority: tick+adj_hr same cycle at 05:00:00 -> 05:00:01, adj_hr ignored.
REQ-033 SHALL test reset mid-sequence: rst in MIN_O of 00:59:59 -> next cycle all zeros (24h), busy 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the time digit sequencer: FSM state encoding,
// per-digit limits and the hour range for the selected hour mode.
// Build option: define HOUR_24_EN for a 00..23 hour range; otherwise 01..12.
package clock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    SEC_O = 3'd1,
    SEC_T = 3'd2,
    MIN_O = 3'd3,
    MIN_T = 3'd4,
    HR    = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Highest value a ones digit / a seconds-minutes tens digit may hold.
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

`ifdef HOUR_24_EN
  // 00..23, wrap 23 -> 00, reset to 00.
  localparam logic [3:0] HR_MAX_T = 4'd2;
  localparam logic [3:0] HR_MAX_O = 4'd3;
  localparam logic [3:0] HR_MIN_T = 4'd0;
  localparam logic [3:0] HR_MIN_O = 4'd0;
  localparam logic [3:0] HR_RST_T = 4'd0;
  localparam logic [3:0] HR_RST_O = 4'd0;
`else
  // 01..12, wrap 12 -> 01, reset to 12.
  localparam logic [3:0] HR_MAX_T = 4'd1;
  localparam logic [3:0] HR_MAX_O = 4'd2;
  localparam logic [3:0] HR_MIN_T = 4'd0;
  localparam logic [3:0] HR_MIN_O = 4'd1;
  localparam logic [3:0] HR_RST_T = 4'd1;
  localparam logic [3:0] HR_RST_O = 4'd2;
`endif

endpackage

// File: rtl/CLA4.sv
// 4-bit carry-lookahead adder. Carry-out is not provided: the sequencer only
// ever increments a BCD digit that is below 9, so the sum never overflows.
module CLA4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum
);

  logic [3:0] p;
  logic [2:0] g;
  logic [3:0] c;

  // Propagate/generate terms and flattened lookahead carries.
  always_comb begin
    p    = a ^ b;
    g    = a[2:0] & b[2:0];
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end

endmodule

// File: rtl/time_digit_sequencer.sv
// BCD hh:mm:ss clock that updates one digit per cycle through a single shared
// incrementer. tick advances seconds with full carry, adj_min bumps minutes
// without hour carry, adj_hr bumps hours. One tick may queue while busy.
// Build option: HOUR_24_EN selects a 00..23 hour range (default 01..12).
//
// Handshake: tick/adj_min/adj_hr are single-cycle request pulses with no
// ready; a request is taken when sampled on a rising edge. busy is high while
// a sequence runs, done pulses for the single completing cycle, tick_miss
// pulses the cycle after a tick was dropped because one was already queued.
module time_digit_sequencer
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               adj_min,
  input  logic               adj_hr,
  output logic [3:0]         sec_o,
  output logic [3:0]         sec_t,
  output logic [3:0]         min_o,
  output logic [3:0]         min_t,
  output logic [3:0]         hr_o,
  output logic [3:0]         hr_t,
  output logic               busy,
  output logic               done,
  output logic               tick_miss,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic       seq_min_q, seq_min_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick_miss_q, tick_miss_d;
  logic [3:0] sec_o_q, sec_o_d, sec_t_q, sec_t_d;
  logic [3:0] min_o_q, min_o_d, min_t_q, min_t_d;
  logic [3:0] hr_o_q, hr_o_d, hr_t_q, hr_t_d;
  logic [3:0] cla_a, cla_sum;

  // Route the digit owned by the current state into the shared incrementer.
  always_comb begin
    cla_a = 4'd0;
    unique case (state_q)
      SEC_O:   cla_a = sec_o_q;
      SEC_T:   cla_a = sec_t_q;
      MIN_O:   cla_a = min_o_q;
      MIN_T:   cla_a = min_t_q;
      HR:      cla_a = hr_o_q;
      default: cla_a = 4'd0;
    endcase
  end

  CLA4 u_cla4 (
    .a   (cla_a),
    .b   (4'd0),
    .cin (1'b1),
    .sum (cla_sum)
  );

  // Next-state, digit writes, tick queueing and registered status outputs.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    seq_min_d   = seq_min_q;
    tick_miss_d = 1'b0;
    sec_o_d     = sec_o_q;
    sec_t_d     = sec_t_q;
    min_o_d     = min_o_q;
    min_t_d     = min_t_q;
    hr_o_d      = hr_o_q;
    hr_t_d      = hr_t_q;

    // A tick that cannot start now is queued once; a second one is dropped.
    if (tick) begin
      if (pending_q)            tick_miss_d = 1'b1;
      else if (state_q != IDLE) pending_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = SEC_O;
          pending_d = 1'b0;
          seq_min_d = 1'b0;
        end else if (tick) begin
          state_d   = SEC_O;
          seq_min_d = 1'b0;
        end else if (adj_hr) begin
          state_d   = HR;
          seq_min_d = 1'b0;
        end else if (adj_min) begin
          state_d   = MIN_O;
          seq_min_d = 1'b1;
        end
      end
      SEC_O: begin
        if (sec_o_q < ONES_MAX) begin
          sec_o_d = cla_sum;
          state_d = DONE;
        end else begin
          sec_o_d = 4'd0;
          state_d = SEC_T;
        end
      end
      SEC_T: begin
        if (sec_t_q < TENS_MAX) begin
          sec_t_d = cla_sum;
          state_d = DONE;
        end else begin
          sec_t_d = 4'd0;
          state_d = MIN_O;
        end
      end
      MIN_O: begin
        if (min_o_q < ONES_MAX) begin
          min_o_d = cla_sum;
          state_d = DONE;
        end else begin
          min_o_d = 4'd0;
          state_d = MIN_T;
        end
      end
      MIN_T: begin
        if (min_t_q < TENS_MAX) begin
          min_t_d = cla_sum;
          state_d = DONE;
        end else begin
          // Minute adjust never carries into the hour field.
          min_t_d = 4'd0;
          state_d = seq_min_q ? DONE : HR;
        end
      end
      HR: begin
        // Hours move as one field: ones via the adder, tens via compares.
        if (hr_t_q == HR_MAX_T && hr_o_q == HR_MAX_O) begin
          hr_t_d = HR_MIN_T;
          hr_o_d = HR_MIN_O;
        end else if (hr_o_q == ONES_MAX) begin
          hr_o_d = 4'd0;
          hr_t_d = (hr_t_q == 4'd0) ? 4'd1 : 4'd2;
        end else begin
          hr_o_d = cla_sum;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and digit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      seq_min_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_miss_q <= 1'b0;
      sec_o_q     <= 4'd0;
      sec_t_q     <= 4'd0;
      min_o_q     <= 4'd0;
      min_t_q     <= 4'd0;
      hr_o_q      <= HR_RST_O;
      hr_t_q      <= HR_RST_T;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      seq_min_q   <= seq_min_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tick_miss_q <= tick_miss_d;
      sec_o_q     <= sec_o_d;
      sec_t_q     <= sec_t_d;
      min_o_q     <= min_o_d;
      min_t_q     <= min_t_d;
      hr_o_q      <= hr_o_d;
      hr_t_q      <= hr_t_d;
    end
  end

  assign sec_o     = sec_o_q;
  assign sec_t     = sec_t_q;
  assign min_o     = min_o_q;
  assign min_t     = min_t_q;
  assign hr_o      = hr_o_q;
  assign hr_t      = hr_t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tick_miss = tick_miss_q;
  assign state_dbg = state_q;

endmodule
